// File: rtl/sdram_cmd_arbiter.sv
// SDRAM command arbiter: init sequencer, auto-refresh and NCH access channels onto one pad bus.
// Optional round-robin channel selection when SDRAM_ARB_RR_EN is defined (fixed priority otherwise).
module sdram_cmd_arbiter #(
    parameter int unsigned NCH    = 2,
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned BA_W   = 2,
    parameter int unsigned DQ_W   = 16,
    parameter int unsigned DQM_W  = 2,
    localparam int unsigned CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [3:0]             init_cmd,
    input  logic [ADDR_W-1:0]      init_addr,
    input  logic                   flag_init_end,
    input  logic                   aref_req,
    output logic                   aref_en,
    input  logic [3:0]             aref_cmd,
    input  logic [ADDR_W-1:0]      aref_addr,
    input  logic                   flag_aref_end,
    input  logic [NCH-1:0]         ch_req,
    output logic [NCH-1:0]         ch_en,
    input  logic [NCH-1:0]         ch_end,
    input  logic [4*NCH-1:0]       ch_cmd,
    input  logic [ADDR_W*NCH-1:0]  ch_addr,
    input  logic [BA_W*NCH-1:0]    ch_ba,
    input  logic [NCH-1:0]         ch_wr_dir,
    input  logic [DQ_W*NCH-1:0]    ch_wdata,
    output logic [3:0]             sdram_cmd,
    output logic [ADDR_W-1:0]      sdram_addr,
    output logic [BA_W-1:0]        sdram_ba,
    output logic [DQM_W-1:0]       sdram_dqm,
    output logic [DQ_W-1:0]        dq_out,
    output logic                   dq_oe,
    output logic [CH_W-1:0]        cur_ch
);

    localparam logic [3:0] CMD_NOP = 4'b0111;

    typedef enum logic [3:0] {
        StIdle  = 4'b0001,
        StArbit = 4'b0010,
        StAref  = 4'b0100,
        StChan  = 4'b1000
    } state_e;

    state_e state_q, state_d;

    logic              grant;
    logic              force_nop;
    logic [CH_W-1:0]   win;
    logic [CH_W-1:0]   sel;
    logic [NCH-1:0]    grant_vec;
    logic [3:0]        sel_cmd;
    logic [ADDR_W-1:0] sel_addr;
    logic [BA_W-1:0]   sel_ba;
    logic              sel_wr;
    logic [DQ_W-1:0]   sel_wdata;

    assign sdram_dqm = '0;

`ifdef SDRAM_ARB_RR_EN
    logic [CH_W-1:0] rr_ptr;
    logic [CH_W-1:0] rr_idx;

    // Descending scan so the closest index after the pointer is the last (winning) assignment.
    always_comb begin
        win    = '0;
        rr_idx = '0;
        for (int unsigned k = NCH; k >= 1; k--) begin
            rr_idx = CH_W'((32'(rr_ptr) + k) % NCH);
            if (ch_req[rr_idx]) begin
                win = rr_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= CH_W'(NCH - 1);
        end else if (grant) begin
            rr_ptr <= win;
        end
    end
`else
    always_comb begin
        win = '0;
        for (int i = int'(NCH) - 1; i >= 0; i--) begin
            if (ch_req[CH_W'(i)]) begin
                win = CH_W'(i);
            end
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        grant     = 1'b0;
        force_nop = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (flag_init_end) begin
                    state_d = StArbit;
                end
            end
            StArbit: begin
                if (aref_req) begin
                    state_d = StAref;
                end else if (|ch_req) begin
                    state_d = StChan;
                    grant   = 1'b1;
                end
            end
            StAref: begin
                if (flag_aref_end) begin
                    state_d = StArbit;
                end
            end
            StChan: begin
                if (ch_end[cur_ch]) begin
                    state_d = StArbit;
                end
            end
            default: begin
                state_d   = StIdle;
                force_nop = 1'b1;
            end
        endcase
    end

    // Channel feeding the pads next cycle: the new winner on a grant, else the held channel.
    assign sel = grant ? win : cur_ch;

    always_comb begin
        grant_vec = '0;
        sel_cmd   = '0;
        sel_addr  = '0;
        sel_ba    = '0;
        sel_wr    = 1'b0;
        sel_wdata = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            grant_vec[i] = (CH_W'(i) == win);
            if (CH_W'(i) == sel) begin
                sel_cmd   = ch_cmd[4*i +: 4];
                sel_addr  = ch_addr[ADDR_W*i +: ADDR_W];
                sel_ba    = ch_ba[BA_W*i +: BA_W];
                sel_wr    = ch_wr_dir[i];
                sel_wdata = ch_wdata[DQ_W*i +: DQ_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            aref_en    <= 1'b0;
            ch_en      <= '0;
            cur_ch     <= '0;
            dq_oe      <= 1'b0;
            dq_out     <= '0;
            sdram_cmd  <= CMD_NOP;
            sdram_addr <= '0;
            sdram_ba   <= '0;
        end else begin
            state_q  <= state_d;
            aref_en  <= (state_d == StAref);
            ch_en    <= grant ? grant_vec : '0;
            dq_oe    <= 1'b0;
            sdram_ba <= '0;
            if (grant) begin
                cur_ch <= win;
            end
            unique case (state_d)
                StIdle: begin
                    sdram_cmd  <= force_nop ? CMD_NOP : init_cmd;
                    sdram_addr <= init_addr;
                end
                StArbit: begin
                    sdram_cmd  <= CMD_NOP;
                    sdram_addr <= init_addr;
                end
                StAref: begin
                    sdram_cmd  <= aref_cmd;
                    sdram_addr <= aref_addr;
                end
                StChan: begin
                    sdram_cmd  <= sel_cmd;
                    sdram_addr <= sel_addr;
                    sdram_ba   <= sel_ba;
                    dq_oe      <= sel_wr;
                    dq_out     <= sel_wdata;
                end
                default: begin
                    sdram_cmd <= CMD_NOP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// Self-checking bench for sdram_cmd_arbiter (NCH=3): directed steps plus randomized transactions
// checked against a transaction-level model of grant order and pad contents.
module tb_sdram_cmd_arbiter;

    localparam int NCH    = 3;
    localparam int ADDR_W = 13;
    localparam int BA_W   = 2;
    localparam int DQ_W   = 16;
    localparam int DQM_W  = 2;
    localparam int CH_W   = 2;
    localparam logic [3:0] NOP = 4'b0111;

    logic                  clk;
    logic                  rst_n;
    logic [3:0]            init_cmd;
    logic [ADDR_W-1:0]     init_addr;
    logic                  flag_init_end;
    logic                  aref_req;
    logic                  aref_en;
    logic [3:0]            aref_cmd;
    logic [ADDR_W-1:0]     aref_addr;
    logic                  flag_aref_end;
    logic [NCH-1:0]        ch_req;
    logic [NCH-1:0]        ch_en;
    logic [NCH-1:0]        ch_end;
    logic [4*NCH-1:0]      ch_cmd;
    logic [ADDR_W*NCH-1:0] ch_addr;
    logic [BA_W*NCH-1:0]   ch_ba;
    logic [NCH-1:0]        ch_wr_dir;
    logic [DQ_W*NCH-1:0]   ch_wdata;
    logic [3:0]            sdram_cmd;
    logic [ADDR_W-1:0]     sdram_addr;
    logic [BA_W-1:0]       sdram_ba;
    logic [DQM_W-1:0]      sdram_dqm;
    logic [DQ_W-1:0]       dq_out;
    logic                  dq_oe;
    logic [CH_W-1:0]       cur_ch;

    sdram_cmd_arbiter #(
        .NCH   (NCH),
        .ADDR_W(ADDR_W),
        .BA_W  (BA_W),
        .DQ_W  (DQ_W),
        .DQM_W (DQM_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .init_cmd     (init_cmd),
        .init_addr    (init_addr),
        .flag_init_end(flag_init_end),
        .aref_req     (aref_req),
        .aref_en      (aref_en),
        .aref_cmd     (aref_cmd),
        .aref_addr    (aref_addr),
        .flag_aref_end(flag_aref_end),
        .ch_req       (ch_req),
        .ch_en        (ch_en),
        .ch_end       (ch_end),
        .ch_cmd       (ch_cmd),
        .ch_addr      (ch_addr),
        .ch_ba        (ch_ba),
        .ch_wr_dir    (ch_wr_dir),
        .ch_wdata     (ch_wdata),
        .sdram_cmd    (sdram_cmd),
        .sdram_addr   (sdram_addr),
        .sdram_ba     (sdram_ba),
        .sdram_dqm    (sdram_dqm),
        .dq_out       (dq_out),
        .dq_oe        (dq_oe),
        .cur_ch       (cur_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int mptr;
    int w;
    int blen;
    int nwait;
    int exp_order[4];
    logic ar;
    logic [NCH-1:0] req;
    logic [DQ_W-1:0] last_wd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Arbitration rule: fixed lowest-index, or first requester after the last winner.
    function automatic int pick(input logic [NCH-1:0] r, input int ptr);
`ifdef SDRAM_ARB_RR_EN
        for (int k = 1; k <= NCH; k++) begin
            if (r[(ptr + k) % NCH]) return (ptr + k) % NCH;
        end
`else
        for (int i = 0; i < NCH; i++) begin
            if (r[i]) return i;
        end
`endif
        return -1;
    endfunction

    task automatic rand_chans();
        for (int i = 0; i < NCH; i++) begin
            ch_cmd[4*i +: 4]             = 4'($urandom);
            ch_addr[ADDR_W*i +: ADDR_W]  = 13'($urandom);
            ch_ba[BA_W*i +: BA_W]        = 2'($urandom);
            ch_wdata[DQ_W*i +: DQ_W]     = 16'($urandom);
            ch_wr_dir[i]                 = 1'($urandom);
        end
    endtask

    task automatic chk_chan(input string tag, input int ch);
        chk({tag, ".cmd"},   32'(sdram_cmd),  32'(ch_cmd[4*ch +: 4]));
        chk({tag, ".addr"},  32'(sdram_addr), 32'(ch_addr[ADDR_W*ch +: ADDR_W]));
        chk({tag, ".ba"},    32'(sdram_ba),   32'(ch_ba[BA_W*ch +: BA_W]));
        chk({tag, ".dq_oe"}, 32'(dq_oe),      32'(ch_wr_dir[ch]));
        chk({tag, ".dqout"}, 32'(dq_out),     32'(ch_wdata[DQ_W*ch +: DQ_W]));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".cmd"},     32'(sdram_cmd),  32'(NOP));
        chk({tag, ".aref_en"}, 32'(aref_en),    32'(0));
        chk({tag, ".ch_en"},   32'(ch_en),      32'(0));
        chk({tag, ".cur_ch"},  32'(cur_ch),     32'(0));
        chk({tag, ".dq_oe"},   32'(dq_oe),      32'(0));
        chk({tag, ".dq_out"},  32'(dq_out),     32'(0));
        chk({tag, ".addr"},    32'(sdram_addr), 32'(0));
        chk({tag, ".ba"},      32'(sdram_ba),   32'(0));
        chk({tag, ".dqm"},     32'(sdram_dqm),  32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
`ifdef SDRAM_ARB_RR_EN
        exp_order = '{0, 1, 2, 0};
`else
        exp_order = '{0, 0, 0, 0};
`endif
        rst_n = 1'b0; init_cmd = 4'b0; init_addr = '0; flag_init_end = 1'b0;
        aref_req = 1'b0; aref_cmd = 4'b0; aref_addr = '0; flag_aref_end = 1'b0;
        ch_req = '0; ch_end = '0; ch_cmd = '0; ch_addr = '0; ch_ba = '0;
        ch_wr_dir = '0; ch_wdata = '0;
        mptr = NCH - 1;

        // Reset values, then IDLE passes the init sequencer through one cycle late
        repeat (2) step();
        chk_reset("rst");
        rst_n = 1'b1;
        init_cmd = 4'b0010; init_addr = 13'h0400;
        step();
        chk("idle.cmd0", 32'(sdram_cmd), 32'(4'b0010));
        chk("idle.addr", 32'(sdram_addr), 32'(13'h0400));
        init_cmd = 4'b0001;
        step();
        chk("idle.cmd1", 32'(sdram_cmd), 32'(4'b0001));
        flag_init_end = 1'b1;
        step();
        flag_init_end = 1'b0;
        chk("arbit.cmd0", 32'(sdram_cmd), 32'(NOP));
        step();
        chk("arbit.cmd1", 32'(sdram_cmd), 32'(NOP));
        chk("arbit.ch_en", 32'(ch_en), 32'(0));

        // Refresh beats channel requests; one ARBIT cycle precedes the next grant
        rand_chans();
        aref_cmd = 4'b0001; aref_addr = 13'h0123;
        aref_req = 1'b1; ch_req = 3'b011;
        step();
        aref_req = 1'b0;
        chk("aref.en", 32'(aref_en), 32'(1));
        chk("aref.ch_en", 32'(ch_en), 32'(0));
        chk("aref.cmd", 32'(sdram_cmd), 32'(4'b0001));
        chk("aref.addr", 32'(sdram_addr), 32'(13'h0123));
        step();
        chk("aref.hold", 32'(aref_en), 32'(1));
        flag_aref_end = 1'b1;
        step();
        flag_aref_end = 1'b0;
        chk("aref.drop", 32'(aref_en), 32'(0));
        chk("aref.gap", 32'(ch_en), 32'(0));
        step();
        chk("grant0.ch_en", 32'(ch_en), 32'(3'b001));
        chk("grant0.cur", 32'(cur_ch), 32'(0));
        chk_chan("grant0", 0);
        mptr = 0;
        ch_req = '0; ch_end = 3'b001;
        step();
        ch_end = '0;
        chk("end0.cmd", 32'(sdram_cmd), 32'(NOP));
        chk("end0.ch_en", 32'(ch_en), 32'(0));

        // Write channel 1: DQ driven, foreign ch_end ignored
        ch_req = 3'b010; ch_wr_dir = 3'b010;
        ch_ba[3:2] = 2'b10; ch_wdata[31:16] = 16'hA5A5;
        step();
        ch_req = '0;
        chk("wr1.ch_en", 32'(ch_en), 32'(3'b010));
        chk("wr1.cur", 32'(cur_ch), 32'(1));
        chk("wr1.dq_oe", 32'(dq_oe), 32'(1));
        chk("wr1.ba", 32'(sdram_ba), 32'(2'b10));
        chk("wr1.dq_out", 32'(dq_out), 32'(16'hA5A5));
        mptr = 1;
        ch_end = 3'b001;
        step();
        chk("wr1.ign_end", 32'(dq_oe), 32'(1));
        chk("wr1.pulse", 32'(ch_en), 32'(0));
        ch_end = 3'b010;
        step();
        ch_end = '0;
        chk("wr1.exit_oe", 32'(dq_oe), 32'(0));
        chk("wr1.exit_ba", 32'(sdram_ba), 32'(0));
        chk("wr1.exit_cmd", 32'(sdram_cmd), 32'(NOP));
        chk("wr1.hold_dq", 32'(dq_out), 32'(16'hA5A5));

        // Asynchronous reset in the middle of a write burst
        ch_req = 3'b100; ch_wr_dir = 3'b100;
        step();
        ch_req = '0;
        chk("rstmid.grant", 32'(ch_en), 32'(3'b100));
        chk("rstmid.oe", 32'(dq_oe), 32'(1));
        step();
        #2 rst_n = 1'b0;
        #1 chk_reset("rstmid");
        aref_req = 1'b1; ch_req = 3'b111;
        step();
        rst_n = 1'b1;
        init_cmd = 4'b0010;
        step();
        chk("rstrel.cmd", 32'(sdram_cmd), 32'(4'b0010));
        chk("rstrel.aref", 32'(aref_en), 32'(0));
        step();
        chk("rstrel.ch_en", 32'(ch_en), 32'(0));
        chk("rstrel.cmd2", 32'(sdram_cmd), 32'(4'b0010));
        aref_req = 1'b0;
        flag_init_end = 1'b1;
        step();
        flag_init_end = 1'b0;
        chk("rstrel.arbit", 32'(sdram_cmd), 32'(NOP));
        mptr = NCH - 1;

        // All channels requesting, 4-cycle bursts
        for (int g = 0; g < 4; g++) begin
            step();
            chk($sformatf("order%0d.cur", g), 32'(cur_ch), 32'(exp_order[g]));
            chk($sformatf("order%0d.en", g), 32'(ch_en), 32'(1) << exp_order[g]);
            step();
            chk($sformatf("order%0d.pulse", g), 32'(ch_en), 32'(0));
            repeat (2) step();
            ch_end = 3'(32'(1) << exp_order[g]);
            step();
            ch_end = '0;
        end
        ch_req = '0;
        mptr = exp_order[3];

        // Randomized transactions against the model
        for (int t = 0; t < 60; t++) begin
            rand_chans();
            req = 3'($urandom_range(1, 7));
            ar = ($urandom_range(0, 3) == 0);
            aref_cmd = 4'($urandom); aref_addr = 13'($urandom);
            ch_req = req; aref_req = ar;
            step();
            aref_req = 1'b0; ch_req = '0;
            if (ar) begin
                chk("r.aref_en", 32'(aref_en), 32'(1));
                chk("r.aref_ch_en", 32'(ch_en), 32'(0));
                chk("r.aref_cmd", 32'(sdram_cmd), 32'(aref_cmd));
                chk("r.aref_addr", 32'(sdram_addr), 32'(aref_addr));
                chk("r.aref_oe", 32'(dq_oe), 32'(0));
                nwait = $urandom_range(0, 2);
                for (int c = 0; c < nwait; c++) begin
                    step();
                    chk("r.aref_hold", 32'(aref_en), 32'(1));
                end
                flag_aref_end = 1'b1;
                step();
                flag_aref_end = 1'b0;
                chk("r.aref_end", 32'(aref_en), 32'(0));
                chk("r.aref_nop", 32'(sdram_cmd), 32'(NOP));
            end else begin
                w = pick(req, mptr);
                mptr = w;
                chk("r.ch_en", 32'(ch_en), 32'(1) << w);
                chk("r.cur", 32'(cur_ch), 32'(w));
                chk_chan("r.first", w);
                last_wd = ch_wdata[DQ_W*w +: DQ_W];
                blen = $urandom_range(1, 4);
                for (int c = 1; c <= blen; c++) begin
                    rand_chans();
                    ch_end = 3'($urandom) & ~3'(32'(1) << w);
                    if (c == blen) ch_end = ch_end | 3'(32'(1) << w);
                    step();
                    ch_end = '0;
                    if (c < blen) begin
                        chk_chan("r.burst", w);
                        chk("r.burst_en", 32'(ch_en), 32'(0));
                        last_wd = ch_wdata[DQ_W*w +: DQ_W];
                    end else begin
                        chk("r.end_cmd", 32'(sdram_cmd), 32'(NOP));
                        chk("r.end_oe", 32'(dq_oe), 32'(0));
                        chk("r.end_ba", 32'(sdram_ba), 32'(0));
                        chk("r.end_addr", 32'(sdram_addr), 32'(init_addr));
                        chk("r.end_dq", 32'(dq_out), 32'(last_wd));
                    end
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sdram_cmd_arbiter.md
Name: sdram_cmd_arbiter

Overview:
Parametrised SDRAM command arbiter, successor to the fixed init/refresh/write/read top-level arbitration.
- Multiplexes the init sequencer, the auto-refresh block and NCH generic access channels (read or write engines) onto one SDRAM command/address/bank/DQ bus.
- Per-channel bank address, per-channel DQ direction, registered pad outputs, and fixed-priority or round-robin channel selection.
- Sits between the sub-engines and the pad/tristate wrapper.

Parameters:
NCH, 2, number of access channels (1..8)
ADDR_W, 13, SDRAM address width
BA_W, 2, bank address width
DQ_W, 16, data bus width
DQM_W, 2, data mask width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
init_cmd  in  4  {cs_n,ras_n,cas_n,we_n} from init sequencer
init_addr  in  ADDR_W  address from init sequencer
flag_init_end  in  1  one-cycle pulse: init done
aref_req  in  1  refresh request (level)
aref_en  out  1  refresh grant, level, held until flag_aref_end
aref_cmd  in  4  refresh command
aref_addr  in  ADDR_W  refresh address
flag_aref_end  in  1  refresh complete pulse
ch_req  in  NCH  per-channel request (level)
ch_en  out  NCH  per-channel grant, one-cycle pulse
ch_end  in  NCH  per-channel burst-complete pulse
ch_cmd  in  4*NCH  packed channel commands, ch i at [4i+3:4i]
ch_addr  in  ADDR_W*NCH  packed channel addresses
ch_ba  in  BA_W*NCH  packed channel bank addresses
ch_wr_dir  in  NCH  1 = channel drives DQ (write engine)
ch_wdata  in  DQ_W*NCH  packed channel write data
sdram_cmd  out  4  registered command to pads
sdram_addr  out  ADDR_W  registered address
sdram_ba  out  BA_W  registered bank
sdram_dqm  out  DQM_W  constant all zeros
dq_out  out  DQ_W  registered write data
dq_oe  out  1  registered DQ output enable
cur_ch  out  clog2(NCH) or 1  index of channel currently granted

Behaviour:
- State encoding is one-hot: IDLE, ARBIT, AREF, CHAN.
- Reset (async, rst_n=0):
  - state IDLE; aref_en=0; ch_en=0; cur_ch=0; dq_oe=0; dq_out=0; sdram_addr=0; sdram_ba=0.
  - sdram_cmd=4'b0111 (NOP); round-robin pointer=NCH-1.
  - Reset mid-burst aborts immediately with no completion handshake.
- IDLE: exit to ARBIT on the edge where flag_init_end=1.
- ARBIT, evaluated each cycle, priority order:
  - aref_req=1 -> next state AREF, aref_en<=1.
  - Else any ch_req=1 -> next state CHAN, cur_ch<=winner, ch_en[winner]<=1 for exactly that one cycle.
  - Else stay in ARBIT.
- AREF: aref_en held at 1. On flag_aref_end=1 -> ARBIT, with aref_en<=0 on the same edge.
- CHAN:
  - Exit to ARBIT when ch_end[cur_ch]=1, checked from the first CHAN cycle.
  - ch_end of non-granted channels is ignored.
  - aref_req never preempts; channel engines terminate their own bursts on aref_req.
- Winner selection, fixed priority (default): lowest set index of ch_req.
- Back-to-back: after any exit the block spends at least one cycle in ARBIT before the next grant.
- Output mux is selected by the next state and registered, so pads are 1 cycle behind the source:
  - IDLE: init_cmd / init_addr.
  - ARBIT: NOP / init_addr.
  - AREF: aref_cmd / aref_addr.
  - CHAN: ch_cmd / ch_addr / ch_ba of the next-state channel.
  - Outside CHAN, sdram_ba=0.
- dq_oe<=1 only when next state is CHAN and ch_wr_dir[selected]=1. dq_out<=ch_wdata[selected] whenever in CHAN, otherwise it holds.
- Illegal state -> IDLE, with NOP output.

Optional Feature:
SDRAM_ARB_RR_EN
- Defined: round-robin channel selection. The search starts at (pointer+1) mod NCH and wraps. The pointer is updated to the winner on each grant, so with all channels requesting, grants rotate 0,1,...,NCH-1,0.
- Undefined: fixed priority, lowest index wins; the pointer logic is not compiled.

Test Plan:
- Reset, init_cmd=4'b0010, then flag_init_end pulse -> sdram_cmd follows init_cmd with 1-cycle delay; state reaches ARBIT the next cycle; sdram_cmd=4'b0111 thereafter.
- In ARBIT, aref_req=1 and ch_req=2'b11 together -> aref_en=1 (no ch_en); after flag_aref_end, aref_en=0, then ch_en=2'b01 pulses for 1 cycle, with at least one ARBIT cycle in between.
- ch1 granted, ch_wr_dir[1]=1, ch_ba[1]=2'b10, ch_wdata[1]=16'hA5A5 -> the cycle after entry dq_oe=1, sdram_ba=2'b10, dq_out=16'hA5A5. ch_end[0] pulse is ignored; ch_end[1] pulse -> ARBIT, dq_oe=0.
- NCH=3, ch_req=3'b111 held, with each burst ending after 4 cycles:
  - with SDRAM_ARB_RR_EN: grant order 0,1,2,0.
  - without it: grant order 0,0,0,0.
- rst_n asserted low mid-CHAN with dq_oe=1 -> all outputs return to reset values immediately (asynchronously); after release the block is in IDLE awaiting flag_init_end.
